// File: rtl/imm_encoder_pkg.sv
// Shared types for the immediate encoder: format codes and the S1 request record.
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6
  } imm_fmt_e;

  localparam int unsigned INSTR_W = 32;

  // Raw fmt bits are kept so an unknown code still reaches the packer.
  typedef struct packed {
    logic [2:0]         fmt;
    logic [INSTR_W-1:0] tpl;
    logic [INSTR_W-1:0] imm;
  } req_t;

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational packer: scatters the immediate into the instruction template
// for the selected format and flags immediates the format cannot represent.
module imm_pack
  import imm_encoder_pkg::*;
#(
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic [2:0]         i_fmt,
  input  logic [INSTR_W-1:0] i_template,
  input  logic [INSTR_W-1:0] i_imm,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_err
);

  imm_fmt_e           w_fmt;
  logic [INSTR_W-1:0] w_instr;
  logic               w_err;
  logic               w_fit12;
  logic               w_fit13;
  logic               w_fit21;

  assign w_fmt = imm_fmt_e'(i_fmt);

  // Sign-extension checks: all bits above the field's sign bit must match it.
  assign w_fit12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_fit13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign w_fit21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

  always_comb begin
    w_instr = i_template;
    w_err   = 1'b0;
    case (w_fmt)
      FMT_R: begin
        w_err = 1'b0;
      end
      FMT_I: begin
        w_instr[31:20] = i_imm[11:0];
        w_err          = ~w_fit12;
      end
      FMT_S: begin
        w_instr[31:25] = i_imm[11:5];
        w_instr[11:7]  = i_imm[4:0];
        w_err          = ~w_fit12;
      end
      FMT_B: begin
        w_instr[31]    = i_imm[12];
        w_instr[30:25] = i_imm[10:5];
        w_instr[11:8]  = i_imm[4:1];
        w_instr[7]     = i_imm[11];
        w_err          = ~w_fit13 | i_imm[0];
      end
      FMT_U: begin
        w_instr[31:12] = i_imm[31:12];
        w_err          = |i_imm[11:0];
      end
      FMT_J: begin
        w_instr[31]    = i_imm[20];
        w_instr[30:21] = i_imm[10:1];
        w_instr[20]    = i_imm[11];
        w_instr[19:12] = i_imm[19:12];
        w_err          = ~w_fit21 | i_imm[0];
      end
      FMT_Z: begin
        w_instr[19:15] = i_imm[4:0];
        w_err          = |i_imm[31:5];
      end
      default: begin
        // Unknown code: template passes through untouched, word is flagged.
        w_err = 1'b1;
      end
    endcase
  end

  assign o_instr = w_instr;
  assign o_err   = CHECK_RANGE ? w_err : 1'b0;

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline around imm_pack: S1 holds the request, S2 the
// packed word; in_ready is combinational on out_ready (no skid buffer).
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_fmt,
  input  logic [INSTR_W-1:0] in_template,
  input  logic [INSTR_W-1:0] in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_err,
  output logic [CNT_W-1:0]   enc_count,
  output logic [CNT_W-1:0]   err_count
);

  logic               r_s1_v;
  req_t               r_s1;
  logic               r_s2_v;
  logic [INSTR_W-1:0] r_s2_instr;
  logic               r_s2_err;
  logic [CNT_W-1:0]   r_enc_cnt;
  logic [CNT_W-1:0]   r_err_cnt;

  logic               w_adv1;
  logic               w_adv2;
  logic               w_out_hs;
  logic [INSTR_W-1:0] w_pk_instr;
  logic               w_pk_err;

  assign w_adv2   = ~r_s2_v | out_ready;
  assign w_adv1   = ~r_s1_v | w_adv2;
  assign w_out_hs = r_s2_v & out_ready;

  assign in_ready = w_adv1 & rst_n;

  imm_pack #(
    .CHECK_RANGE (CHECK_RANGE)
  ) u_pack (
    .i_fmt      (r_s1.fmt),
    .i_template (r_s1.tpl),
    .i_imm      (r_s1.imm),
    .o_instr    (w_pk_instr),
    .o_err      (w_pk_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s1   <= '0;
    end else if (w_adv1) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1 <= '{fmt: in_fmt, tpl: in_template, imm: in_imm};
      end
    end
  end

  // S2 only reloads when it is free or being drained, so a stalled word holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_v     <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_adv2) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_instr <= w_pk_instr;
        r_s2_err   <= w_pk_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_out_hs) begin
      r_enc_cnt <= r_enc_cnt + CNT_W'(1);
      if (r_s2_err) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_s2_v;
  assign out_instr = r_s2_instr;
  assign out_err   = r_s2_err;
  assign enc_count = r_enc_cnt;
  assign err_count = r_err_cnt;

endmodule
